// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped branch target buffer with a saturating-counter
//            direction predictor. IF looks up the fetch PC every cycle and
//            gets a predicted next PC with zero latency. EX reports resolved
//            control flow: the table is trained, and a redirect is raised on
//            a mispredict. A sequential invalidate walks the table after a
//            flush request.
// Ports    : clk_i / rst_ni         clock, asynchronous active-low reset
//            if_pc_i                fetch PC
//            pred_taken_o           predicted taken for if_pc_i
//            pred_target_o          predicted next PC for if_pc_i
//            ex_*_i                 resolved instruction from EX
//            mispredict_o           flush IF/ID and redirect
//            redirect_pc_o          correct next PC of the EX instruction
//            flush_i / busy_o       start table invalidate / invalidate running
//            perf_ctrl_o            resolved control-flow count
//            perf_mispred_o         mispredict count
// Config   : `define BPU_PERF_EN to build the performance counters; when it
//            is undefined both perf ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 32,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_is_ctrl_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [31:0] perf_ctrl_o,
    output logic [31:0] perf_mispred_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0] c_cnt_weak_t = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] c_cnt_weak_n = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_min    = {CNT_W{1'b0}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_clr_idx;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [29:0]      r_target [ENTRIES];
    logic [CNT_W-1:0] r_cnt    [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup: purely combinational on the current table contents, so a
    // same-cycle update to the same index is only visible next cycle.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;

    assign w_if_idx = if_pc_i[IDX_W+1:2];
    assign w_if_tag = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag) &&
                      (r_state == S_IDLE);

    assign pred_taken_o  = w_if_hit && r_cnt[w_if_idx][CNT_W-1];
    assign pred_target_o = pred_taken_o ? {r_target[w_if_idx], 2'b00}
                                        : if_pc_i + 32'd4;

    // ------------------------------------------------------------------
    // Resolve: compare what was predicted against the real next PC. A
    // non-control instruction predicted taken falls out naturally as a
    // mispredict to ex_pc_i + 4.
    // ------------------------------------------------------------------
    logic [31:0] w_act_next;

    assign w_act_next    = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
    assign mispredict_o  = ex_valid_i &&
                           ((ex_pred_taken_i != ex_taken_i) ||
                            (ex_pred_target_i != w_act_next));
    assign redirect_pc_o = w_act_next;

    // ------------------------------------------------------------------
    // Training side
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_upd_en;

    assign w_ex_idx = ex_pc_i[IDX_W+1:2];
    assign w_ex_tag = ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_upd_en = ex_valid_i && (r_state == S_IDLE);

    assign busy_o = (r_state == S_CLEAR);

    // Table and invalidate FSM share one process: the walk only runs in
    // CLEAR and training only in IDLE, so their writes never collide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_clr_idx <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= c_cnt_weak_n;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        r_state   <= S_CLEAR;
                        r_clr_idx <= '0;
                    end
                end
                S_CLEAR: begin
                    r_valid[r_clr_idx] <= 1'b0;
                    if (flush_i) begin
                        r_clr_idx <= '0;
                    end else if (r_clr_idx == c_last_idx) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_clr_idx <= r_clr_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_upd_en) begin
                if (ex_is_ctrl_i) begin
                    if (w_ex_hit) begin
                        if (ex_taken_i) begin
                            r_target[w_ex_idx] <= ex_target_i[31:2];
                            if (r_cnt[w_ex_idx] != c_cnt_max)
                                r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + CNT_W'(1);
                        end else if (r_cnt[w_ex_idx] != c_cnt_min) begin
                            r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - CNT_W'(1);
                        end
                    end else if (ex_taken_i) begin
                        r_valid[w_ex_idx]  <= 1'b1;
                        r_tag[w_ex_idx]    <= w_ex_tag;
                        r_target[w_ex_idx] <= ex_target_i[31:2];
                        r_cnt[w_ex_idx]    <= c_cnt_weak_t;
                    end
                end else if (w_ex_hit) begin
                    // A non-control instruction matched: the entry is an
                    // alias and would keep steering fetch wrongly.
                    r_valid[w_ex_idx] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
`ifdef BPU_PERF_EN
    logic [31:0] r_perf_ctrl;
    logic [31:0] r_perf_mispred;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_ctrl    <= 32'h0;
            r_perf_mispred <= 32'h0;
        end else begin
            if (ex_valid_i && ex_is_ctrl_i)
                r_perf_ctrl <= r_perf_ctrl + 32'd1;
            if (mispredict_o)
                r_perf_mispred <= r_perf_mispred + 32'd1;
        end
    end

    assign perf_ctrl_o    = r_perf_ctrl;
    assign perf_mispred_o = r_perf_mispred;
`else
    assign perf_ctrl_o    = 32'h0;
    assign perf_mispred_o = 32'h0;
`endif

endmodule
`default_nettype wire
